// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 serial transmitter with a small byte FIFO.
// Stores to the TX data address enqueue bytes; loads of the status address
// return {overflow, busy, full, empty}. A baud-timed FSM drains the FIFO.
module mmio_uart_tx #(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [31:0] TX_DATA_ADDR = 32'h10010024,
  parameter logic [31:0] STATUS_ADDR  = 32'h10010028
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [31:0] ReadData,
  output logic        Hit,
  output logic        TxSerial,
  output logic        TxBusy
);

  localparam int               PTR_W     = $clog2(FIFO_DEPTH);
  localparam int               CNT_W     = PTR_W + 1;
  localparam logic [15:0]      BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} txState_t;

  txState_t         state, stateNext;
  logic [7:0]       fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0] rdPtr, wrPtr;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic [15:0]      baudCnt;
  logic [2:0]       bitIdx, idxNext;
  logic [7:0]       shiftReg;
  logic             txReg, serialNext;
  logic             txSel, statusSel, pushReq, statusRd;
  logic             fifoEmpty, fifoFull, pop, pushOk, overflowSet, baudEnd;

  assign txSel       = (Address == TX_DATA_ADDR);
  assign statusSel   = (Address == STATUS_ADDR);
  assign Hit         = txSel | statusSel;
  assign pushReq     = MemWrite & txSel;
  assign statusRd    = MemRead & statusSel;
  assign fifoEmpty   = (count == '0);
  assign fifoFull    = (count == CNT_FULL);
  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign pushOk      = pushReq & (~fifoFull | pop);
  assign overflowSet = pushReq & fifoFull & ~pop;
  assign baudEnd     = (baudCnt == BAUD_LAST);
  assign TxBusy      = (state != IDLE) | ~fifoEmpty;
  assign TxSerial    = txReg;
  assign ReadData    = statusRd ? {28'b0, overflow, TxBusy, fifoFull, fifoEmpty} : 32'b0;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Next-state, pop decision and the next registered line level.
  always_comb begin
    stateNext  = state;
    pop        = 1'b0;
    idxNext    = bitIdx;
    serialNext = 1'b1;
    case (state)
      IDLE: begin
        if (!fifoEmpty) begin
          pop       = 1'b1;
          stateNext = START;
        end
      end
      START: if (baudEnd) stateNext = DATA;
      DATA:  if (baudEnd && bitIdx == 3'd7) stateNext = STOP;
      STOP: begin
        if (baudEnd) begin
          if (!fifoEmpty) begin
            pop       = 1'b1;
            stateNext = START;
          end else begin
            stateNext = IDLE;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
    if (state == START)               idxNext = 3'd0;
    else if (state == DATA && baudEnd) idxNext = bitIdx + 3'd1;
    case (stateNext)
      START:   serialNext = 1'b0;
      DATA:    serialNext = shiftReg[idxNext];
      default: serialNext = 1'b1;
    endcase
  end

  // Bit timing, bit index and the registered serial line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baudCnt <= '0;
      bitIdx  <= '0;
      txReg   <= 1'b1;
    end else begin
      if (state == IDLE || baudEnd) baudCnt <= '0;
      else                          baudCnt <= baudCnt + 16'd1;
      bitIdx <= idxNext;
      txReg  <= serialNext;
    end
  end

  // Shift register loads the FIFO head on every pop; no reset needed.
  always_ff @(posedge clk) begin
    if (pop) shiftReg <= fifoMem[rdPtr];
  end

  // FIFO storage write port; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (pushOk) fifoMem[wrPtr] <= WriteData[7:0];
  end

  // FIFO pointers, occupancy and sticky overflow (set wins over read-clear).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdPtr    <= '0;
      wrPtr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + 1'b1;
      if (pop)    rdPtr <= rdPtr + 1'b1;
      case ({pushOk, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (overflowSet)   overflow <= 1'b1;
      else if (statusRd) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_mmio_uart_tx;

  localparam int          CPB    = 4;
  localparam int          FR     = 10 * CPB;
  localparam logic [31:0] TXA    = 32'h10010024;
  localparam logic [31:0] STA    = 32'h10010028;

  logic        clk, reset;
  logic [31:0] Address, WriteData, ReadData;
  logic        MemWrite, MemRead, Hit, TxSerial, TxBusy;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  txBytes [8];
  int          pushAt  [8];
  int          rdAt    [2];
  logic [31:0] rdExp   [2];

  mmio_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .TX_DATA_ADDR(TXA), .STATUS_ADDR(STA)) dut (
    .clk(clk), .reset(reset), .Address(Address), .WriteData(WriteData),
    .MemWrite(MemWrite), .MemRead(MemRead), .ReadData(ReadData), .Hit(Hit),
    .TxSerial(TxSerial), .TxBusy(TxBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected line level at sample j (taken after edge j, push of first byte at edge 0).
  function automatic logic expSerial(input int j, input int nFrames);
    int p, f, slot;
    if (j < 1 || j > FR * nFrames) return 1'b1;
    p    = (j - 1) % FR;
    f    = (j - 1) / FR;
    slot = p / CPB;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return txBytes[f][slot-1];
  endfunction

  task automatic clearSchedule();
    for (int k = 0; k < 8; k++) begin
      txBytes[k] = 8'h00;
      pushAt[k]  = -1;
    end
    rdAt[0] = -1; rdAt[1] = -1;
    rdExp[0] = 32'h0; rdExp[1] = 32'h0;
  endtask

  task automatic idleBus();
    MemWrite = 1'b0; MemRead = 1'b0; Address = 32'h0; WriteData = 32'h0;
  endtask

  // Drives the push/read schedule and checks every sample of the resulting frames.
  task automatic runStream(input string name, input int nFrames);
    int last;
    logic [31:0] exp;
    last = FR * nFrames + 2;
    @(negedge clk);
    for (int j = 0; j <= last; j++) begin
      idleBus();
      for (int k = 0; k < 8; k++)
        if (pushAt[k] == j) begin
          MemWrite = 1'b1; Address = TXA; WriteData = {24'h0, txBytes[k]};
        end
      if (j == last || j == rdAt[0] || j == rdAt[1]) begin
        MemRead = 1'b1; Address = STA;
        #1;
        exp = (j == last) ? 32'h1 : ((j == rdAt[0]) ? rdExp[0] : rdExp[1]);
        vectors++;
        if (ReadData !== exp) begin
          miscompares++;
          $display("FAIL %s status@%0d: got %h want %h", name, j, ReadData, exp);
        end
      end
      @(negedge clk);
      vectors++;
      if (TxSerial !== expSerial(j, nFrames) || TxBusy !== (j >= 0 && j <= FR * nFrames)) begin
        miscompares++;
        $display("FAIL %s line@%0d: got ser=%b busy=%b want ser=%b busy=%b", name, j,
                 TxSerial, TxBusy, expSerial(j, nFrames), (j <= FR * nFrames));
      end
    end
    idleBus();
  endtask

  task automatic test_reset();
    reset = 1'b1; idleBus();
    repeat (2) @(negedge clk);
    MemRead = 1'b1; Address = STA;
    #1;
    vectors++;
    if (TxSerial !== 1'b1 || TxBusy !== 1'b0 || ReadData !== 32'h1 || Hit !== 1'b1) begin
      miscompares++;
      $display("FAIL reset: got ser=%b busy=%b rd=%h hit=%b want 1 0 00000001 1", TxSerial, TxBusy, ReadData, Hit);
    end
    @(negedge clk);
    reset = 1'b0; idleBus();
  endtask

  task automatic test_single();
    clearSchedule();
    txBytes[0] = 8'h55; pushAt[0] = 0;
    runStream("single", 1);
  endtask

  task automatic test_back_to_back();
    clearSchedule();
    txBytes[0] = 8'hA1; pushAt[0] = 0;
    txBytes[1] = 8'hB2; pushAt[1] = 1;
    txBytes[2] = 8'hC3; pushAt[2] = 2;
    runStream("b2b", 3);
  endtask

  task automatic test_overflow();
    clearSchedule();
    txBytes[0] = 8'h11; txBytes[1] = 8'h22; txBytes[2] = 8'h33;
    txBytes[3] = 8'h44; txBytes[4] = 8'h55; txBytes[5] = 8'h66;
    for (int k = 0; k < 6; k++) pushAt[k] = k;
    rdAt[0] = 6; rdExp[0] = 32'hE;
    rdAt[1] = 7; rdExp[1] = 32'h6;
    runStream("overflow", 5);
  endtask

  task automatic test_push_on_pop();
    clearSchedule();
    txBytes[0] = 8'h01; txBytes[1] = 8'h80; txBytes[2] = 8'h3C;
    txBytes[3] = 8'hC3; txBytes[4] = 8'hFF; txBytes[5] = 8'h5A;
    for (int k = 0; k < 5; k++) pushAt[k] = k;
    pushAt[5] = 41;
    rdAt[0] = 42; rdExp[0] = 32'h6;
    runStream("pushpop", 6);
  endtask

  task automatic test_reset_mid_frame();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      MemWrite = 1'b1; Address = TXA; WriteData = (k == 0) ? 32'h00 : ((k == 1) ? 32'h0F : 32'hF0);
      @(negedge clk);
    end
    idleBus();
    repeat (8) @(negedge clk);
    vectors++;
    if (TxSerial !== 1'b0 || TxBusy !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset pre: got ser=%b busy=%b want 0 1", TxSerial, TxBusy);
    end
    #2 reset = 1'b1;
    MemRead = 1'b1; Address = STA;
    #1;
    vectors++;
    if (TxSerial !== 1'b1 || TxBusy !== 1'b0 || ReadData !== 32'h1) begin
      miscompares++;
      $display("FAIL midreset async: got ser=%b busy=%b rd=%h want 1 0 00000001", TxSerial, TxBusy, ReadData);
    end
    @(negedge clk);
    reset = 1'b0; idleBus();
    for (int j = 0; j < 60; j++) begin
      @(negedge clk);
      vectors++;
      if (TxSerial !== 1'b1 || TxBusy !== 1'b0) begin
        miscompares++;
        $display("FAIL midreset after@%0d: got ser=%b busy=%b want 1 0", j, TxSerial, TxBusy);
      end
    end
  endtask

  task automatic test_decode();
    @(negedge clk);
    Address = STA; MemRead = 1'b0;
    #1;
    vectors++;
    if (Hit !== 1'b1 || ReadData !== 32'h0) begin
      miscompares++;
      $display("FAIL decode status-noread: got hit=%b rd=%h want 1 00000000", Hit, ReadData);
    end
    Address = TXA; MemRead = 1'b1;
    #1;
    vectors++;
    if (Hit !== 1'b1 || ReadData !== 32'h0) begin
      miscompares++;
      $display("FAIL decode txread: got hit=%b rd=%h want 1 00000000", Hit, ReadData);
    end
    Address = 32'h10010000; MemRead = 1'b1; MemWrite = 1'b1; WriteData = 32'hAA;
    #1;
    vectors++;
    if (Hit !== 1'b0 || ReadData !== 32'h0) begin
      miscompares++;
      $display("FAIL decode miss: got hit=%b rd=%h want 0 00000000", Hit, ReadData);
    end
    @(negedge clk);
    Address = STA; MemRead = 1'b0; MemWrite = 1'b1;
    @(negedge clk);
    idleBus();
    repeat (2) @(negedge clk);
    MemRead = 1'b1; Address = STA;
    #1;
    vectors++;
    if (TxBusy !== 1'b0 || TxSerial !== 1'b1 || ReadData !== 32'h1) begin
      miscompares++;
      $display("FAIL decode nowrite: got busy=%b ser=%b rd=%h want 0 1 00000001", TxBusy, TxSerial, ReadData);
    end
    @(negedge clk);
    idleBus();
  endtask

  initial begin
    idleBus();
    reset = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_push_on_pop();
    test_reset_mid_frame();
    test_decode();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
